unary_add_driver: RTL and testbench

- Host-side driver for the 8-bit unary accumulator.
- Accepts two binary operands over a valid/ready handshake and serialises each operand as a unary pulse train on lanes A and B, with en=1 and read_or_write=0 (read phase).
- Then switches the accumulator to write phase and counts the unary dout pulses back into a binary sum.
- Returns the sum plus the sticky carry/overflow flag C on a valid/ready result port.

---
 rtl/unary_add_driver.sv | 140 ++++++++++++++
 tb/tb_unary_add_driver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/unary_add_driver.sv
// rtl/unary_add_driver.sv - host driver that feeds a unary accumulator and counts its drain back to binary
module unary_add_driver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             A,
    output logic             B,
    output logic             en,
    output logic             read_or_write,
    input  logic             dout,
    input  logic             C,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEND    = 3'd1,
        S_TURN    = 3'd2,
        S_COLLECT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             res_ovf_q, res_ovf_d;

    // A remainder of 0 or 1 is exhausted after the current SEND cycle
    logic last_send;
    assign last_send = (ra_q[WIDTH-1:1] == '0) && (rb_q[WIDTH-1:1] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ra_q      <= '0;
            rb_q      <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            sum_q     <= sum_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (in_valid) state_d = S_SEND;
            S_SEND:    if (last_send) state_d = S_TURN;
            S_TURN:    state_d = S_COLLECT;
            S_COLLECT: if (!dout) state_d = S_DONE;
            S_DONE:    if (out_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ra_d      = ra_q;
        rb_d      = rb_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        sum_d     = sum_q;
        res_ovf_d = res_ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ra_d  = in_a;
                    rb_d  = in_b;
                    acc_d = '0;
                    ovf_d = 1'b0;
                end
            end
            S_SEND: begin
                if (ra_q != '0) ra_d = ra_q - WIDTH'(1);
                if (rb_q != '0) rb_d = rb_q - WIDTH'(1);
                ovf_d = ovf_q | C;
            end
            // The carry from the final SEND cycle only becomes visible here
            S_TURN: ovf_d = ovf_q | C;
            S_COLLECT: begin
                if (dout) begin
                    acc_d = acc_q + WIDTH'(1);
                end else begin
                    sum_d     = acc_q;
                    res_ovf_d = ovf_q;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        en            = 1'b0;
        read_or_write = 1'b0;
        A             = 1'b0;
        B             = 1'b0;
        busy          = 1'b0;
        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_SEND: begin
                en   = 1'b1;
                busy = 1'b1;
                A    = (ra_q != '0);
                B    = (rb_q != '0);
            end
            S_TURN, S_COLLECT: begin
                en            = 1'b1;
                read_or_write = 1'b1;
                busy          = 1'b1;
            end
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    assign out_sum = sum_q;
    assign out_ovf = res_ovf_q;

endmodule

// File: tb/tb_unary_add_driver.sv
// tb/tb_unary_add_driver.sv - self-checking bench with a behavioural unary accumulator
module tb_unary_add_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'd0;
    logic [7:0] in_b = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_sum;
    logic       out_ovf;
    logic       A, B, en, rw, busy;
    logic       dout, C;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    unary_add_driver #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf),
        .A(A), .B(B), .en(en), .read_or_write(rw), .dout(dout), .C(C), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Accumulator model: counts A+B in read phase with a sticky wrap carry,
    // drains one registered dout pulse per cycle in write phase.
    logic [7:0] m_cnt;
    logic       m_c, m_dout;
    logic [8:0] m_sum9;
    assign m_sum9 = {1'b0, m_cnt} + {8'd0, A} + {8'd0, B};
    assign dout = m_dout;
    assign C = m_c;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 8'd0;
            m_c    <= 1'b0;
            m_dout <= 1'b0;
        end else if (en && !rw) begin
            m_cnt  <= m_sum9[7:0];
            m_c    <= m_c | m_sum9[8];
            m_dout <= 1'b0;
        end else if (en && rw) begin
            m_c    <= 1'b0;
            m_dout <= (m_cnt != 8'd0);
            if (m_cnt != 8'd0) m_cnt <= m_cnt - 8'd1;
        end else begin
            m_dout <= 1'b0;
        end
    end

    typedef struct {
        int a; int b; int sum; int ovf; int lat; int hold; bit junk;
    } vec_t;

    typedef struct {
        int sum; int ovf; int lat; int acnt; int bcnt; int slen;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int max3(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : m;
    endfunction

    task automatic run_txn(input int a, input int b, input int hold, input bit junk);
        exp_t e;
        int   acnt, bcnt, slen, accept, n;
        bit   seen;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_a = a[7:0];
        in_b = b[7:0];
        e.sum  = (a + b) % 256;
        e.ovf  = ((a + b) > 255) ? 1 : 0;
        e.lat  = max3(a, b) + (a + b) % 256 + 2;
        e.acnt = a;
        e.bcnt = b;
        e.slen = max3(a, b);
        sb.push_back(e);
        accept = cyc + 1;
        acnt = 0; bcnt = 0; slen = 0; seen = 1'b0;
        for (int i = 0; i < 1200 && !seen; i++) begin
            @(negedge clk);
            if (junk) begin
                in_a = 8'($urandom);
                in_b = 8'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                seen = 1'b1;
            end else begin
                if (en && !rw) begin
                    slen++;
                    acnt += int'(A);
                    bcnt += int'(B);
                end
                check("en_eq_busy", en, busy);
                check("in_ready_low_busy", in_ready, 0);
                if (rw) check("rw_only_busy", busy, 1);
                if (!en || rw) check("lanes_idle", A | B, 0);
            end
        end
        in_valid = 1'b0;
        if (!seen) begin
            check("result_timeout", 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        check("out_sum", out_sum, e.sum);
        check("out_ovf", out_ovf, e.ovf);
        check("latency", cyc - accept, e.lat);
        check("a_pulses", acnt, e.acnt);
        check("b_pulses", bcnt, e.bcnt);
        check("send_len", slen, e.slen);
        check("done_en", en, 0);
        check("done_rw", rw, 0);
        check("done_busy", busy, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_sum", out_sum, e.sum);
            check("hold_ovf", out_ovf, e.ovf);
            check("hold_in_ready", in_ready, 0);
            check("hold_en", en, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_take_valid", out_valid, 0);
        check("post_take_in_ready", in_ready, 1);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{a: 3,   b: 5,   sum: 8,   ovf: 0, lat: 15,  hold: 0, junk: 1'b0};
        vecs[1] = '{a: 0,   b: 0,   sum: 0,   ovf: 0, lat: 3,   hold: 0, junk: 1'b0};
        vecs[2] = '{a: 200, b: 100, sum: 44,  ovf: 1, lat: 246, hold: 1, junk: 1'b1};
        vecs[3] = '{a: 255, b: 255, sum: 254, ovf: 1, lat: 511, hold: 0, junk: 1'b0};
        vecs[4] = '{a: 128, b: 128, sum: 0,   ovf: 1, lat: 130, hold: 4, junk: 1'b1};
        vecs[5] = '{a: 1,   b: 0,   sum: 1,   ovf: 0, lat: 4,   hold: 0, junk: 1'b0};
        vecs[6] = '{a: 0,   b: 255, sum: 255, ovf: 0, lat: 512, hold: 2, junk: 1'b0};

        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_en", en, 0);
        check("rst_rw", rw, 0);
        check("rst_ab", A | B, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        check("idle_en", en, 0);

        foreach (vecs[i]) begin
            check("table_sum_consistent", (vecs[i].a + vecs[i].b) % 256, vecs[i].sum);
            run_txn(vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].junk);
        end

        // Reset in the middle of COLLECT
        in_valid = 1'b1;
        in_a = 8'd100;
        in_b = 8'd100;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 300 && !rw; i++) @(negedge clk);
        check("reached_write_phase", rw, 1);
        repeat (20) @(negedge clk);
        check("mid_collect_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_en", en, 0);
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_rw", rw, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(7, 1, 0, 1'b0);

        for (int r = 0; r < 120; r++) begin
            run_txn(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
